// File: rtl/message_packer_pkg.sv
// rtl/message_packer_pkg.sv - shared message framing definitions for the packer and related message blocks
package message_packer_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BODY = 1'b1
    } state_t;

    localparam int DEFAULT_N_SLICES    = 2;
    localparam int DEFAULT_WIDTH       = 32;
    localparam int DEFAULT_LOG_MAX_LEN = 8;

    // Header marker is always the top bit of a message word.
    function automatic int hdr_bit(input int width);
        return width - 1;
    endfunction

    function automatic int ptr_width(input int n_slices);
        return (n_slices > 1) ? $clog2(n_slices) : 1;
    endfunction

endpackage

// File: rtl/message_packer_if.sv
// rtl/message_packer_if.sv - word-in / packed-group-out bus of the message packer
interface message_packer_if #(
    parameter int WIDTH    = 32,
    parameter int N_SLICES = 2
);
    logic [WIDTH-1:0]          in_data;
    logic                      in_nd;
    logic [WIDTH*N_SLICES-1:0] out_data;
    logic                      out_nd;
    logic                      error;

    modport master (output in_data, in_nd, input out_data, out_nd, error);
    modport slave  (input in_data, in_nd, output out_data, out_nd, error);
endinterface

// File: rtl/message_packer.sv
// rtl/message_packer.sv - packs header+payload messages into N_SLICES-word groups, toggle strobe out
module message_packer
    import message_packer_pkg::*;
#(
    parameter int N_SLICES    = DEFAULT_N_SLICES,
    parameter int WIDTH       = DEFAULT_WIDTH,
    parameter int LOG_MAX_LEN = DEFAULT_LOG_MAX_LEN
) (
    input  logic           clk,
    input  logic           rst,
    message_packer_if.slave bus
);

    localparam int HDR_POS = hdr_bit(WIDTH);
    localparam int PTR_W   = ptr_width(N_SLICES);
    localparam logic [PTR_W-1:0] LAST_SLOT = PTR_W'(N_SLICES - 1);

    state_t                         state, state_next;
    logic [PTR_W-1:0]               ptr, ptr_next;
    logic [LOG_MAX_LEN-1:0]         remaining, remaining_next;
    logic [N_SLICES-1:0][WIDTH-1:0] bank;
    logic [N_SLICES-1:0][WIDTH-1:0] group;
    logic                           write;
    logic                           close;
    logic                           set_error;

    always_comb begin
        state_next     = state;
        ptr_next       = ptr;
        remaining_next = remaining;
        write          = 1'b0;
        close          = 1'b0;
        set_error      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus.in_nd) begin
                    if (bus.in_data[HDR_POS]) begin
                        write          = 1'b1;
                        remaining_next = bus.in_data[LOG_MAX_LEN-1:0];
                        if (remaining_next == '0) begin
                            close = 1'b1;
                        end else begin
                            state_next = ST_BODY;
                        end
                    end else begin
                        set_error = 1'b1;
                    end
                end
            end
            ST_BODY: begin
                // Payload words are taken verbatim; the top bit has no meaning here.
                if (bus.in_nd) begin
                    write          = 1'b1;
                    remaining_next = remaining - LOG_MAX_LEN'(1);
                    if (remaining == LOG_MAX_LEN'(1)) begin
                        close      = 1'b1;
                        state_next = ST_IDLE;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
        if (write && ptr == LAST_SLOT) begin
            close = 1'b1;
        end
        if (close) begin
            ptr_next = '0;
        end else if (write) begin
            ptr_next = ptr + PTR_W'(1);
        end
    end

    // Closing group: earlier slots from the bank, current word in its slot, rest zero.
    always_comb begin
        group = '0;
        for (int i = 0; i < N_SLICES; i++) begin
            if (PTR_W'(i) < ptr) begin
                group[i] = bank[i];
            end else if (PTR_W'(i) == ptr) begin
                group[i] = bus.in_data;
            end else begin
                group[i] = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            ptr          <= '0;
            remaining    <= '0;
            bank         <= '0;
            bus.out_data <= '0;
            bus.out_nd   <= 1'b0;
            bus.error    <= 1'b0;
        end else begin
            state     <= state_next;
            ptr       <= ptr_next;
            remaining <= remaining_next;
            if (write) begin
                bank[ptr] <= bus.in_data;
            end
            if (close) begin
                bus.out_data <= group;
                bus.out_nd   <= ~bus.out_nd;
            end
            if (set_error) begin
                bus.error <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_message_packer.sv
// tb/tb_message_packer.sv - directed self-checking bench for message_packer
module tb_message_packer;

    logic clk = 1'b0;
    logic rst;
    int   passed = 0;
    int   total  = 0;

    logic [63:0] exp_data;
    logic        exp_nd;
    logic        exp_err;

    always #5 clk = ~clk;

    message_packer_if #(.WIDTH(32), .N_SLICES(2)) bus ();

    message_packer #(
        .N_SLICES   (2),
        .WIDTH      (32),
        .LOG_MAX_LEN(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    localparam logic [31:0] A = 32'h1111_1111;
    localparam logic [31:0] B = 32'h2222_2222;
    localparam logic [31:0] C = 32'h3333_3333;
    localparam logic [31:0] D = 32'h4444_4444;

    // Present a word (or an idle slot) for one clock; outputs are settled on return.
    task automatic drive(input logic [31:0] w, input logic v);
        bus.in_data = w;
        bus.in_nd   = v;
        @(posedge clk);
        #1;
        bus.in_nd   = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(32'h8000_0000, 1'b1);
        drive(32'h8000_0001, 1'b1);
        exp_data = '0; exp_nd = 1'b0; exp_err = 1'b0;
        total++;
        if ({bus.out_nd, bus.error, bus.out_data} !== {exp_nd, exp_err, exp_data})
            $display("FAIL reset: got nd=%b err=%b data=%h, expected nd=%b err=%b data=%h",
                     bus.out_nd, bus.error, bus.out_data, exp_nd, exp_err, exp_data);
        else passed++;
        rst = 1'b0;
        drive(32'h0, 1'b0);
        total++;
        if ({bus.out_nd, bus.error, bus.out_data} !== {exp_nd, exp_err, exp_data})
            $display("FAIL reset_release: got nd=%b err=%b data=%h, expected nd=%b err=%b data=%h",
                     bus.out_nd, bus.error, bus.out_data, exp_nd, exp_err, exp_data);
        else passed++;
    endtask

    task automatic test_basic();
        logic [31:0] w[4] = '{32'h8000_0003, A, B, C};
        logic        t[4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        logic [63:0] d[4] = '{64'h0, {A, 32'h8000_0003}, 64'h0, {C, B}};
        for (int i = 0; i < 4; i++) begin
            drive(w[i], 1'b1);
            if (t[i]) begin exp_nd = ~exp_nd; exp_data = d[i]; end
            total++;
            if ({bus.out_nd, bus.error, bus.out_data} !== {exp_nd, exp_err, exp_data})
                $display("FAIL basic[%0d]: got nd=%b err=%b data=%h, expected nd=%b err=%b data=%h",
                         i, bus.out_nd, bus.error, bus.out_data, exp_nd, exp_err, exp_data);
            else passed++;
        end
    endtask

    task automatic test_zero_len();
        drive(32'h8000_0000, 1'b1);
        exp_nd = ~exp_nd; exp_data = {32'h0, 32'h8000_0000};
        total++;
        if ({bus.out_nd, bus.error, bus.out_data} !== {exp_nd, exp_err, exp_data})
            $display("FAIL zero_len: got nd=%b err=%b data=%h, expected nd=%b err=%b data=%h",
                     bus.out_nd, bus.error, bus.out_data, exp_nd, exp_err, exp_data);
        else passed++;
    endtask

    task automatic test_gaps();
        logic [31:0] w[5] = '{32'h8000_0002, A, 32'h0, 32'h0, B};
        logic        v[5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        logic        t[5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        logic [63:0] d[5] = '{64'h0, {A, 32'h8000_0002}, 64'h0, 64'h0, {32'h0, B}};
        for (int i = 0; i < 5; i++) begin
            drive(w[i], v[i]);
            if (t[i]) begin exp_nd = ~exp_nd; exp_data = d[i]; end
            total++;
            if ({bus.out_nd, bus.error, bus.out_data} !== {exp_nd, exp_err, exp_data})
                $display("FAIL gaps[%0d]: got nd=%b err=%b data=%h, expected nd=%b err=%b data=%h",
                         i, bus.out_nd, bus.error, bus.out_data, exp_nd, exp_err, exp_data);
            else passed++;
        end
    endtask

    task automatic test_error();
        logic [31:0] w[4] = '{32'h0000_0005, 32'h0, 32'h8000_0001, D};
        logic        v[4] = '{1'b1, 1'b0, 1'b1, 1'b1};
        logic        t[4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        logic [63:0] d[4] = '{64'h0, 64'h0, 64'h0, {D, 32'h8000_0001}};
        for (int i = 0; i < 4; i++) begin
            drive(w[i], v[i]);
            if (i == 0) exp_err = 1'b1;
            if (t[i]) begin exp_nd = ~exp_nd; exp_data = d[i]; end
            total++;
            if ({bus.out_nd, bus.error, bus.out_data} !== {exp_nd, exp_err, exp_data})
                $display("FAIL error[%0d]: got nd=%b err=%b data=%h, expected nd=%b err=%b data=%h",
                         i, bus.out_nd, bus.error, bus.out_data, exp_nd, exp_err, exp_data);
            else passed++;
        end
    endtask

    task automatic test_reset_mid();
        drive(32'h8000_0003, 1'b1);
        drive(A, 1'b1);
        exp_nd = ~exp_nd; exp_data = {A, 32'h8000_0003};
        drive(B, 1'b1);
        total++;
        if ({bus.out_nd, bus.error, bus.out_data} !== {exp_nd, exp_err, exp_data})
            $display("FAIL reset_mid_pre: got nd=%b err=%b data=%h, expected nd=%b err=%b data=%h",
                     bus.out_nd, bus.error, bus.out_data, exp_nd, exp_err, exp_data);
        else passed++;
        rst = 1'b1;
        drive(C, 1'b1);
        rst = 1'b0;
        exp_nd = 1'b0; exp_err = 1'b0; exp_data = '0;
        total++;
        if ({bus.out_nd, bus.error, bus.out_data} !== {exp_nd, exp_err, exp_data})
            $display("FAIL reset_mid_cleared: got nd=%b err=%b data=%h, expected nd=%b err=%b data=%h",
                     bus.out_nd, bus.error, bus.out_data, exp_nd, exp_err, exp_data);
        else passed++;
        drive(32'h8000_0000, 1'b1);
        exp_nd = ~exp_nd; exp_data = {32'h0, 32'h8000_0000};
        total++;
        if ({bus.out_nd, bus.error, bus.out_data} !== {exp_nd, exp_err, exp_data})
            $display("FAIL reset_mid_after: got nd=%b err=%b data=%h, expected nd=%b err=%b data=%h",
                     bus.out_nd, bus.error, bus.out_data, exp_nd, exp_err, exp_data);
        else passed++;
    endtask

    task automatic test_back_to_back();
        logic [31:0] w[8] = '{32'h8055_0001, 32'h8000_0007, 32'h8000_0000, 32'h8000_0004, A, B, C, D};
        logic        t[8] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        logic [63:0] d[8] = '{64'h0, {32'h8000_0007, 32'h8055_0001}, {32'h0, 32'h8000_0000}, 64'h0,
                              {A, 32'h8000_0004}, 64'h0, {C, B}, {32'h0, D}};
        for (int i = 0; i < 8; i++) begin
            drive(w[i], 1'b1);
            if (t[i]) begin exp_nd = ~exp_nd; exp_data = d[i]; end
            total++;
            if ({bus.out_nd, bus.error, bus.out_data} !== {exp_nd, exp_err, exp_data})
                $display("FAIL back_to_back[%0d]: got nd=%b err=%b data=%h, expected nd=%b err=%b data=%h",
                         i, bus.out_nd, bus.error, bus.out_data, exp_nd, exp_err, exp_data);
            else passed++;
        end
        drive(32'h0, 1'b0);
        total++;
        if ({bus.out_nd, bus.error, bus.out_data} !== {exp_nd, exp_err, exp_data})
            $display("FAIL back_to_back_hold: got nd=%b err=%b data=%h, expected nd=%b err=%b data=%h",
                     bus.out_nd, bus.error, bus.out_data, exp_nd, exp_err, exp_data);
        else passed++;
    endtask

    initial begin
        rst         = 1'b1;
        bus.in_data = '0;
        bus.in_nd   = 1'b0;
        exp_data    = '0;
        exp_nd      = 1'b0;
        exp_err     = 1'b0;
        @(posedge clk);
        #1;
        test_reset();
        test_basic();
        test_zero_len();
        test_gaps();
        test_error();
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
